cfar_param_detector: RTL
========================

CFAR_PARAM_DETECTOR -- requirements
Module: cfar_param_detector

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 16, unsigned power sample width.
REQ-002 SHALL have parameter INDEX_WIDTH, default 10, sample index width.
REQ-003 SHALL have parameter NUM_TRAIN, default 4, training cells per side (>=1).
REQ-004 SHALL have parameter NUM_GUARD, default 2, guard cells per side (>=1).
REQ-005 SHALL have parameter ALPHA_WIDTH, default 8, and ALPHA_FRAC, default 4: unsigned fixed-point scale format.
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port input_valid  input  1  power_in/index_in/eop_in valid this cycle.
REQ-009 SHALL have port power_in  input  INPUT_WIDTH  cell power.
REQ-010 SHALL have port index_in  input  INDEX_WIDTH  cell index, carried with the sample.
REQ-011 SHALL have port eop_in  input  1  last sample of frame, qualified by input_valid.
REQ-012 SHALL have port mode  input  2  00 CA, 01 SOCA, 10 GOCA, 11 treated as CA.
REQ-013 SHALL have port alpha  input  ALPHA_WIDTH  threshold scale.
REQ-014 SHALL have port max_valid  output  1  one-cycle detection pulse.
REQ-015 SHALL have port index_out  output  INDEX_WIDTH  index of detected cell.
REQ-016 SHALL have port power_out  output  INPUT_WIDTH  power of detected cell.
REQ-017 SHALL have port frame_done  output  1  one-cycle end-of-frame pulse.

Function
REQ-018 Window W=2*NUM_TRAIN+2*NUM_GUARD+1 cells; CUT at centre; window SHALL shift only on input_valid; idle cycles SHALL NOT alter state.
REQ-019 Lagging/leading sums SHALL be maintained incrementally (add entering, subtract leaving cell), width INPUT_WIDTH+clog2(NUM_TRAIN)+1, never overflowing.
REQ-020 Noise S: CA lead+lag; SOCA 2*min(lead,lag); GOCA 2*max(lead,lag).
REQ-021 Detect SHALL be CUT*2*NUM_TRAIN*2^ALPHA_FRAC > S*alpha, strictly greater, full-width products, no truncation.
REQ-022 FSM IDLE->FILL on first valid sample; FILL->RUN when W samples held; RUN/FILL->IDLE on accepted eop_in.
REQ-023 mode and alpha SHALL be sampled on the first valid sample of a frame and held for the frame.
REQ-024 Only cells with a full window SHALL be tested; first and last NUM_TRAIN+NUM_GUARD cells of a frame SHALL never detect.
REQ-025 Latency: sample accepted at edge E completes a window; compare registered at edge E+1; max_valid/index_out/power_out SHALL be valid in the cycle after E+1.
REQ-026 index_out/power_out SHALL hold last detection values when max_valid is low.
REQ-027 frame_done SHALL pulse in the same cycle the eop sample's compare result is presented, including frames shorter than W (no detections).
REQ-028 Sample arriving the cycle after eop SHALL start a new frame with cleared window; no cross-frame cell mixing.

Reset
REQ-029 reset SHALL clear window, sums, FSM (IDLE), latched mode/alpha; max_valid, frame_done, index_out, power_out SHALL be 0 the cycle after reset is sampled.
REQ-030 reset mid-frame SHALL abort the frame with no detection or frame_done emitted for it.

Configuration
REQ-031 Macro CFAR_LOCAL_MAX_EN defined: detection additionally requires CUT >= both adjacent (guard) cells.
REQ-032 Macro undefined: local-max check absent; detection per REQ-021 only.

Verification (INPUT_WIDTH 16, NUM_TRAIN 4, NUM_GUARD 2, alpha 48 = 3.0, mode CA unless stated)
REQ-033 64-sample frame, all 100, spike 1000 at index 20 -> one max_valid, index_out 20, power_out 1000; one frame_done.
REQ-034 Flat 100, spike 300 at 20 -> no detection; spike 301 -> detection at 20.
REQ-035 Indices 0..31 = 100, 32..63 = 1000, 2000 at 28 -> SOCA detects 28; GOCA does not detect 28.
REQ-036 Spike 1000 at index 3 -> no detection; REQ-033 stimulus with input_valid low every other cycle -> identical detection.
REQ-037 Spikes 1000 at 20, 1200 at 21 -> macro defined: only 21; undefined: 20 and 21.
REQ-038 reset 2 cycles at sample 30 -> outputs 0, no frame_done; next REQ-033 frame detects index 20.

Source files
------------

// File: rtl/cfar_param_detector.sv
`default_nettype none
// ============================================================================
//  Module   : cfar_param_detector
//  Purpose  : Sliding-window CFAR detector (CA / SOCA / GOCA) with framed input.
//             Optional macro CFAR_LOCAL_MAX_EN adds a CUT local-maximum gate.
//  Revision : 1.0 - initial release
// ============================================================================
module cfar_param_detector #(
    parameter int INPUT_WIDTH = 16,
    parameter int INDEX_WIDTH = 10,
    parameter int NUM_TRAIN   = 4,
    parameter int NUM_GUARD   = 2,
    parameter int ALPHA_WIDTH = 8,
    parameter int ALPHA_FRAC  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   input_valid,
    input  logic [INPUT_WIDTH-1:0] power_in,
    input  logic [INDEX_WIDTH-1:0] index_in,
    input  logic                   eop_in,
    input  logic [1:0]             mode,
    input  logic [ALPHA_WIDTH-1:0] alpha,
    output logic                   max_valid,
    output logic [INDEX_WIDTH-1:0] index_out,
    output logic [INPUT_WIDTH-1:0] power_out,
    output logic                   frame_done
);

    localparam int W       = 2*NUM_TRAIN + 2*NUM_GUARD + 1;
    localparam int CUT     = NUM_TRAIN + NUM_GUARD;
    localparam int SUM_W   = INPUT_WIDTH + $clog2(NUM_TRAIN) + 1;
    localparam int NOISE_W = SUM_W + 1;
    localparam int CNT_W   = $clog2(W + 1);
    localparam int PROD_W  = INPUT_WIDTH + $clog2(NUM_TRAIN) + ALPHA_WIDTH + ALPHA_FRAC + 4;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_FILL = 2'd1, ST_RUN = 2'd2} state_t;

    state_t                 state_q, state_d;
    logic [INPUT_WIDTH-1:0] win_q [W];
    logic [INPUT_WIDTH-1:0] win_d [W];
    logic [INDEX_WIDTH-1:0] idx_q [W];
    logic [INDEX_WIDTH-1:0] idx_d [W];
    logic [SUM_W-1:0]       lead_q, lead_d, lag_q, lag_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [1:0]             mode_q, mode_d;
    logic [ALPHA_WIDTH-1:0] alpha_q, alpha_d;
    logic                   chk_q, chk_d, eop_q, eop_d;
    logic                   max_valid_q, max_valid_d, frame_done_q, frame_done_d;
    logic [INDEX_WIDTH-1:0] index_out_q, index_out_d;
    logic [INPUT_WIDTH-1:0] power_out_q, power_out_d;

    logic                   w_first, w_full;
    logic [NOISE_W-1:0]     w_noise;
    logic [PROD_W-1:0]      w_lhs, w_rhs;
    logic                   w_local_max, w_det;

    assign w_first = (state_q == ST_IDLE);

    // Window slot 0 holds the newest sample; the first sample of a frame
    // shifts into an all-zero window so no cells leak across frames.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        idx_d   = idx_q;
        lead_d  = lead_q;
        lag_d   = lag_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        alpha_d = alpha_q;
        chk_d   = 1'b0;
        eop_d   = 1'b0;
        w_full  = 1'b0;
        if (input_valid) begin
            win_d[0] = power_in;
            idx_d[0] = index_in;
            for (int i = 1; i < W; i++) begin
                win_d[i] = w_first ? '0 : win_q[i-1];
                idx_d[i] = w_first ? '0 : idx_q[i-1];
            end
            if (w_first) begin
                lead_d  = SUM_W'(power_in);
                lag_d   = '0;
                cnt_d   = CNT_W'(1);
                mode_d  = mode;
                alpha_d = alpha;
            end else begin
                lead_d = lead_q + SUM_W'(power_in) - SUM_W'(win_q[NUM_TRAIN-1]);
                lag_d  = lag_q + SUM_W'(win_q[CUT+NUM_GUARD]) - SUM_W'(win_q[W-1]);
                if (cnt_q != CNT_W'(W)) cnt_d = cnt_q + CNT_W'(1);
            end
            w_full = (cnt_d == CNT_W'(W));
            chk_d  = w_full;
            eop_d  = eop_in;
            if (eop_in)      state_d = ST_IDLE;
            else if (w_full) state_d = ST_RUN;
            else             state_d = ST_FILL;
        end
    end

    always_comb begin
        w_noise = NOISE_W'(lead_q) + NOISE_W'(lag_q);
        case (mode_q)
            2'b01:   w_noise = (lead_q < lag_q) ? {lead_q, 1'b0} : {lag_q, 1'b0};
            2'b10:   w_noise = (lead_q > lag_q) ? {lead_q, 1'b0} : {lag_q, 1'b0};
            default: w_noise = NOISE_W'(lead_q) + NOISE_W'(lag_q);
        endcase
    end

    assign w_lhs = (PROD_W'(win_q[CUT]) * PROD_W'(2*NUM_TRAIN)) << ALPHA_FRAC;
    assign w_rhs = PROD_W'(w_noise) * PROD_W'(alpha_q);

`ifdef CFAR_LOCAL_MAX_EN
    assign w_local_max = (win_q[CUT] >= win_q[CUT-1]) && (win_q[CUT] >= win_q[CUT+1]);
`else
    assign w_local_max = 1'b1;
`endif

    assign w_det        = chk_q && w_local_max && (w_lhs > w_rhs);
    assign max_valid_d  = w_det;
    assign index_out_d  = w_det ? idx_q[CUT] : index_out_q;
    assign power_out_d  = w_det ? win_q[CUT] : power_out_q;
    assign frame_done_d = eop_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            for (int i = 0; i < W; i++) begin
                win_q[i] <= '0;
                idx_q[i] <= '0;
            end
            lead_q       <= '0;
            lag_q        <= '0;
            cnt_q        <= '0;
            mode_q       <= '0;
            alpha_q      <= '0;
            chk_q        <= 1'b0;
            eop_q        <= 1'b0;
            max_valid_q  <= 1'b0;
            index_out_q  <= '0;
            power_out_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_q        <= win_d;
            idx_q        <= idx_d;
            lead_q       <= lead_d;
            lag_q        <= lag_d;
            cnt_q        <= cnt_d;
            mode_q       <= mode_d;
            alpha_q      <= alpha_d;
            chk_q        <= chk_d;
            eop_q        <= eop_d;
            max_valid_q  <= max_valid_d;
            index_out_q  <= index_out_d;
            power_out_q  <= power_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign max_valid  = max_valid_q;
    assign index_out  = index_out_q;
    assign power_out  = power_out_q;
    assign frame_done = frame_done_q;

endmodule
`default_nettype wire
